// File: rtl/load_store_unit.sv
// Load/store unit: aligns CPU byte/half/word/doubleword accesses onto a
// doubleword-wide data memory, using read-modify-write for sub-doubleword stores.
module load_store_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misaligned,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_write_en,
  output logic            mem_read_en,
  input  logic [XLEN-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t          state, next_state;
  logic            store_q, uns_q, mis_q;
  logic [1:0]      size_q;
  logic [XLEN-1:0] addr_q, wdata_q, data_q;
  logic            accept, req_mis;
  logic [2:0]      off;
  logic [5:0]      bit_off;
  logic [7:0]      size_mask, lane_mask;
  logic [XLEN-1:0] wdata_sh, merged, load_sh, load_ext;

  always_comb begin
    unique case (req_size)
      2'd0:    req_mis = 1'b0;
      2'd1:    req_mis = req_addr[0];
      2'd2:    req_mis = |req_addr[1:0];
      default: req_mis = |req_addr[2:0];
    endcase
  end

  assign accept = req_valid && req_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    next_state   = state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_mis)                 next_state = RESP;
          else if (!req_store)         next_state = READ;
          else if (req_size == 2'b11)  next_state = WRITE;
          else                         next_state = READ;
        end
      end
      READ: begin
        mem_read_en = 1'b1;
        next_state  = store_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_write_en = 1'b1;
        next_state   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Reset overrides combinationally so a write in flight is squashed this cycle.
    if (rst) begin
      next_state   = IDLE;
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
    end
  end

  // NOTE: datapath registers are reset as well, so the address bus and
  // captured data never carry stale values out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      if (accept) begin
        store_q <= req_store;
        uns_q   <= req_unsigned;
        mis_q   <= req_mis;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == READ) data_q <= mem_read_data;
    end
  end

  assign off     = addr_q[2:0];
  assign bit_off = {off, 3'b000};

  always_comb begin
    unique case (size_q)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  assign lane_mask = size_mask << off;
  assign wdata_sh  = wdata_q << bit_off;

  // A doubleword store has every lane selected, so it never depends on data_q.
  always_comb begin
    merged = data_q;
    for (int k = 0; k < 8; k++) begin
      if (lane_mask[k]) merged[8*k +: 8] = wdata_sh[8*k +: 8];
    end
  end

  assign load_sh = data_q >> bit_off;

  always_comb begin
    unique case (size_q)
      2'd0:    load_ext = {{(XLEN-8){!uns_q && load_sh[7]}},   load_sh[7:0]};
      2'd1:    load_ext = {{(XLEN-16){!uns_q && load_sh[15]}}, load_sh[15:0]};
      2'd2:    load_ext = {{(XLEN-32){!uns_q && load_sh[31]}}, load_sh[31:0]};
      default: load_ext = load_sh;
    endcase
  end

  assign mem_address     = rst ? '0 : {addr_q[XLEN-1:3], 3'b000};
  assign mem_write_data  = mem_write_en ? merged : '0;
  assign resp_rdata      = (resp_valid && !store_q && !mis_q) ? load_ext : '0;
  assign resp_misaligned = resp_valid && mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests against a small
// doubleword memory model, responses checked by an independent monitor.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_misaligned;
  logic [63:0] resp_rdata;
  logic [63:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read_en;

  load_store_unit #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [32];
  assign mem_read_data = mem[mem_address[7:3]];
  always @(posedge clk) if (mem_write_en) mem[mem_address[7:3]] <= mem_write_data;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  typedef struct {
    string       name;
    logic [63:0] rdata;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  // Monitor: one scoreboard pop on the first cycle of each response.
  logic seen = 1'b0;
  always @(negedge clk) begin
    if (resp_valid && !seen) begin
      if (sb.size() == 0) check("unexpected_resp", {63'b0, resp_valid}, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_rdata"}, resp_rdata, e.rdata);
        check({e.name, "_mis"}, {63'b0, resp_misaligned}, {63'b0, e.mis});
      end
    end
    seen = resp_valid;
  end

  int          rd_cnt = 0, wr_cnt = 0;
  logic [63:0] last_wr_addr = '0, last_wr_data = '0;
  always @(negedge clk) begin
    if (mem_read_en) rd_cnt++;
    if (mem_write_en) begin
      wr_cnt++;
      last_wr_addr = mem_address;
      last_wr_data = mem_write_data;
    end
    if (mem_read_en && mem_write_en) check("rd_wr_overlap", {63'b0, mem_write_en}, 64'd0);
  end

  task automatic do_req(input string name, input logic st, input logic [1:0] sz,
                        input logic uns, input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input logic exp_mis, input int exp_lat,
                        input int exp_rds, input int exp_wrs, input bit stall);
    int w, lat;
    exp_t e;
    @(negedge clk);
    req_store = st; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    resp_ready = !stall;
    rd_cnt = 0; wr_cnt = 0;
    e.name = name; e.rdata = exp_rd; e.mis = exp_mis;
    sb.push_back(e);
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    check({name, "_req_ready"}, {63'b0, req_ready}, 64'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_reads"}, rd_cnt, exp_rds);
    check({name, "_writes"}, wr_cnt, exp_wrs);
    if (stall) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check({name, "_stall_valid"}, {63'b0, resp_valid}, 64'd1);
        check({name, "_stall_rdata"}, resp_rdata, exp_rd);
        check({name, "_stall_req_ready"}, {63'b0, req_ready}, 64'd0);
      end
      #1 resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    @(negedge clk);
    check({name, "_idle_valid"}, {63'b0, resp_valid}, 64'd0);
    check({name, "_idle_ready"}, {63'b0, req_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {63'b0, req_ready}, 64'd0);
    check("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    check("rst_resp_mis", {63'b0, resp_misaligned}, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_mem_rd_en", {63'b0, mem_read_en}, 64'd0);
    check("rst_mem_wr_en", {63'b0, mem_write_en}, 64'd0);
    check("rst_mem_addr", mem_address, 64'd0);
    check("rst_mem_wdata", mem_write_data, 64'd0);
    rst = 1'b0;

    do_req("dw_st_10", 1, 2'd3, 0, 64'h10, 64'h1122334455667788, 64'd0, 0, 2, 0, 1, 0);
    check("dw_st_10_waddr", last_wr_addr, 64'h10);
    check("dw_st_10_wdata", last_wr_data, 64'h1122334455667788);
    do_req("dw_ld_10", 0, 2'd3, 0, 64'h10, 64'd0, 64'h1122334455667788, 0, 2, 1, 0, 0);
    do_req("b_st_13", 1, 2'd0, 0, 64'h13, 64'hAB, 64'd0, 0, 3, 1, 1, 0);
    check("b_st_13_waddr", last_wr_addr, 64'h10);
    check("b_st_13_wdata", last_wr_data, 64'h11223344AB667788);
    do_req("b_ld_13_s", 0, 2'd0, 0, 64'h13, 64'd0, 64'hFFFFFFFFFFFFFFAB, 0, 2, 1, 0, 0);
    do_req("b_ld_13_u", 0, 2'd0, 1, 64'h13, 64'd0, 64'h00000000000000AB, 0, 2, 1, 0, 0);
    do_req("h_ld_11_mis", 0, 2'd1, 0, 64'h11, 64'd0, 64'd0, 1, 1, 0, 0, 0);
    do_req("h_st_16", 1, 2'd1, 0, 64'h16, 64'hBEEF, 64'd0, 0, 3, 1, 1, 0);
    check("h_st_16_wdata", last_wr_data, 64'hBEEF3344AB667788);
    do_req("h_ld_16_s", 0, 2'd1, 0, 64'h16, 64'd0, 64'hFFFFFFFFFFFFBEEF, 0, 2, 1, 0, 0);
    do_req("w_ld_14_u", 0, 2'd2, 1, 64'h14, 64'd0, 64'h00000000BEEF3344, 0, 2, 1, 0, 0);
    do_req("w_ld_10_stall", 0, 2'd2, 0, 64'h10, 64'd0, 64'hFFFFFFFFAB667788, 0, 2, 1, 0, 1);
    do_req("w_st_12_mis", 1, 2'd2, 0, 64'h12, 64'h12345678, 64'd0, 1, 1, 0, 0, 0);
    do_req("dw_ld_10_u", 0, 2'd3, 1, 64'h10, 64'd0, 64'hBEEF3344AB667788, 0, 2, 1, 0, 0);
    do_req("dw_st_18", 1, 2'd3, 0, 64'h18, 64'hCAFEF00D12345678, 64'd0, 0, 2, 0, 1, 0);

    // Byte store to 0x18 interrupted by reset during its write cycle.
    @(negedge clk);
    req_store = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 64'h18; req_wdata = 64'h5A; req_valid = 1'b1;
    rd_cnt = 0; wr_cnt = 0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rstw_wr_en", {63'b0, mem_write_en}, 64'd0);
    check("rstw_rd_en", {63'b0, mem_read_en}, 64'd0);
    check("rstw_resp_valid", {63'b0, resp_valid}, 64'd0);
    check("rstw_req_ready", {63'b0, req_ready}, 64'd0);
    check("rstw_mem_addr", mem_address, 64'd0);
    check("rstw_mem_wdata", mem_write_data, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstw_idle_ready", {63'b0, req_ready}, 64'd1);
    check("rstw_reads", rd_cnt, 1);
    check("rstw_writes", wr_cnt, 0);
    repeat (3) @(negedge clk);
    do_req("dw_ld_18", 0, 2'd3, 0, 64'h18, 64'd0, 64'hCAFEF00D12345678, 0, 2, 1, 0, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
